lsu_dtcm_ctrl: RTL and testbench
================================

Name: lsu_dtcm_ctrl

Overview:
Load/store control stage that sits directly upstream of the data TCM. It accepts one memory request per handshake from the execute stage and checks it for alignment, address range and legal size. It then drives the TCM's mem_cs/mem_wr/mem_bwen/mem_addr/mem_data with byte-lane-aligned write data. For loads, it extracts and sign/zero-extends the TCM's registered read word and returns a writeback to the register file.

Parameters:
DP, 256, TCM depth in 32-bit words
DW, 32, data width (fixed at 32)
AW, 32, address width of the request and of mem_addr
BASE_ADDR, 32'h2000_0000, byte address of TCM word 0

Ports:
clk  in  1  clock
rst_n  in  1  reset
lsu_valid  in  1  request valid from execute stage
lsu_ready  out  1  stage can accept a request this cycle
lsu_load  in  1  request is a load
lsu_store  in  1  request is a store (load and store both high is illegal)
lsu_funct3  in  3  RV32I width: 0 B, 1 H, 2 W, 4 BU, 5 HU
lsu_addr  in  AW  byte address
lsu_wdata  in  DW  store data, right-aligned
lsu_rd  in  5  load destination register
mem_cs  out  1  TCM chip select
mem_wr  out  1  TCM write (1) / read (0)
mem_bwen  out  4  TCM byte write enables
mem_addr  out  AW  TCM word index
mem_data  out  DW  TCM write data, lane-aligned
mem_data_wb  in  DW  TCM registered read data
wb_valid  out  1  one-cycle load writeback pulse
wb_rd  out  5  writeback register
wb_data  out  DW  extended load result
lsu_err  out  1  one-cycle fault pulse
lsu_err_code  out  2  1 misaligned, 2 out of range, 3 illegal request
lsu_err_addr  out  AW  faulting byte address

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset state: FSM IDLE. wb_valid=0, wb_rd=0, wb_data=0, lsu_err=0, lsu_err_code=0, lsu_err_addr=0, and all captured registers are 0. Upstream holds lsu_valid low while in reset.
- FSM states: IDLE and LOAD_WAIT.
  - lsu_ready=1 only in IDLE.
  - accept = lsu_valid & lsu_ready.
- Mem outputs: mem_* are combinational decode of the accepted request. mem_cs=0 when there is no accept or when the request faults.
  - mem_addr = (lsu_addr - BASE_ADDR) >> 2, zero-extended to AW.
- Fault checks, in priority order:
  - Illegal: neither or both of load/store set, or a funct3 outside the list (stores allow only 0/1/2).
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Out of range: (lsu_addr - BASE_ADDR) >= DP*4, unsigned compare, so addresses below BASE wrap and also fault.
  - A faulting accept: mem_cs=0, no writeback. Next cycle lsu_err=1 with lsu_err_code and lsu_err_addr registered. FSM stays IDLE.
- Store, legal: mem_cs=1, mem_wr=1 in the accept cycle. Store completes there; no writeback; FSM stays IDLE.
  - SB: bwen = 1 << addr[1:0], mem_data = byte replicated x4.
  - SH: bwen = 4'b0011 when addr[1]=0, 4'b1100 when addr[1]=1; mem_data = halfword replicated x2.
  - SW: bwen = 4'b1111, mem_data = lsu_wdata.
- Load, legal:
  - Accept cycle: mem_cs=1, mem_wr=0, bwen=0. Register addr[1:0], funct3 and rd; go to LOAD_WAIT.
  - LOAD_WAIT: mem_data_wb is valid. Select lane by the captured offset and extend (B/H sign-extend, BU/HU zero-extend, W pass-through). Register the result into wb_data with wb_rd and wb_valid=1; return to IDLE.
  - wb_valid pulses in the cycle after LOAD_WAIT, i.e. 2 cycles after accept.
  - Throughput: one load per 2 cycles, one store per cycle.
- wb_data and wb_rd hold their last value when wb_valid=0. lsu_err and wb_valid are never high together.
- Simultaneous events: a store accepted in the cycle a load's wb_valid pulses is legal and independent.
- Reset asserted in LOAD_WAIT: the load is discarded and no wb_valid is produced.

Test Plan:
1. SW addr=BASE+0x10, wdata=32'hDEADBEEF -> accept cycle: mem_cs=1, mem_wr=1, bwen=4'hF, mem_addr=4, mem_data=DEADBEEF; no wb_valid.
2. SB addr=BASE+0x13, wdata=0x5A, then LBU and LB at the same address -> bwen=4'h8, mem_data=5A5A5A5A. wb_data=0000005A, 2 cycles after each accept; lsu_ready low in each LOAD_WAIT.
3. Word 0 preloaded with 0x8001_7F80 -> LH BASE+2 gives FFFF8001; LHU BASE+2 gives 00008001; LB BASE+0 gives FFFFFF80; LW gives 80017F80; wb_rd echoes lsu_rd.
4. LW BASE+0x2 -> mem_cs=0, next cycle lsu_err=1, code=1, err_addr=BASE+2. SH BASE+DP*4 -> code=2. Load with funct3=3 -> code=3. Misaligned address with funct3=7 -> code=3 (priority).
5. Back-to-back: load accepted, store valid next cycle -> store waits one cycle (ready=0) and is accepted in the cycle wb_valid pulses; both complete correctly.
6. Assert rst_n low during LOAD_WAIT -> all outputs 0 immediately; no wb_valid after release; next request is accepted normally.

Source files
------------

// File: rtl/lsu_dtcm_ctrl.sv
// Load/store control stage in front of the data TCM: checks requests, lane-aligns store
// data, and sign/zero-extends the TCM's registered read word into a load writeback.
`timescale 1ns/1ps
module lsu_dtcm_ctrl #(
  parameter int             DP        = 256,
  parameter int             DW        = 32,
  parameter int             AW        = 32,
  parameter logic [AW-1:0]  BASE_ADDR = 32'h2000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lsu_valid,
  output logic          lsu_ready,
  input  logic          lsu_load,
  input  logic          lsu_store,
  input  logic [2:0]    lsu_funct3,
  input  logic [AW-1:0] lsu_addr,
  input  logic [DW-1:0] lsu_wdata,
  input  logic [4:0]    lsu_rd,
  output logic          mem_cs,
  output logic          mem_wr,
  output logic [3:0]    mem_bwen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  input  logic [DW-1:0] mem_data_wb,
  output logic          wb_valid,
  output logic [4:0]    wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          lsu_err,
  output logic [1:0]    lsu_err_code,
  output logic [AW-1:0] lsu_err_addr
);

  localparam logic [2:0]    F3_B  = 3'd0;
  localparam logic [2:0]    F3_H  = 3'd1;
  localparam logic [2:0]    F3_W  = 3'd2;
  localparam logic [2:0]    F3_BU = 3'd4;
  localparam logic [2:0]    F3_HU = 3'd5;

  localparam logic [1:0]    ERR_NONE     = 2'd0;
  localparam logic [1:0]    ERR_MISALIGN = 2'd1;
  localparam logic [1:0]    ERR_RANGE    = 2'd2;
  localparam logic [1:0]    ERR_ILLEGAL  = 2'd3;

  localparam logic [AW-1:0] SPAN = AW'(DP * 4);

  typedef enum logic [0:0] {IDLE, LOAD_WAIT} state_t;

  state_t        state;
  logic          accept;
  logic [AW-1:0] offset;
  logic          f3_load_ok;
  logic          f3_store_ok;
  logic          illegal;
  logic          misaligned;
  logic          out_of_range;
  logic [1:0]    fault_code;
  logic          go;

  // Captured load context, consumed in LOAD_WAIT
  logic [1:0]    off_p1;
  logic [2:0]    funct3_p1;
  logic [4:0]    rd_p1;

  function automatic logic [3:0] store_bwen(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] bw;
    case (f3)
      F3_B:    bw = 4'b0001 << off;
      F3_H:    bw = off[1] ? 4'b1100 : 4'b0011;
      default: bw = 4'b1111;
    endcase
    return bw;
  endfunction

  function automatic logic [DW-1:0] store_lanes(input logic [2:0] f3, input logic [DW-1:0] wd);
    logic [DW-1:0] d;
    case (f3)
      F3_B:    d = {4{wd[7:0]}};
      F3_H:    d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [DW-1:0] load_extend(input logic [DW-1:0] word,
                                                input logic [1:0]    off,
                                                input logic [2:0]    f3);
    logic        [DW-1:0] shifted;
    logic signed [7:0]    b;
    logic signed [15:0]   h;
    logic signed [DW-1:0] res;
    shifted = word >> {off, 3'b000};
    b       = shifted[7:0];
    h       = shifted[15:0];
    case (f3)
      F3_B:    res = {{(DW-8){b[7]}}, b};
      F3_H:    res = {{(DW-16){h[15]}}, h};
      F3_BU:   res = {{(DW-8){1'b0}}, b};
      F3_HU:   res = {{(DW-16){1'b0}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  assign lsu_ready = (state == IDLE);
  assign accept    = lsu_valid & lsu_ready;
  assign offset    = lsu_addr - BASE_ADDR;

  always_comb begin
    f3_load_ok   = (lsu_funct3 == F3_B) | (lsu_funct3 == F3_H) | (lsu_funct3 == F3_W) |
                   (lsu_funct3 == F3_BU) | (lsu_funct3 == F3_HU);
    f3_store_ok  = (lsu_funct3 == F3_B) | (lsu_funct3 == F3_H) | (lsu_funct3 == F3_W);
    illegal      = (lsu_load == lsu_store) |
                   (lsu_load & ~f3_load_ok) |
                   (lsu_store & ~f3_store_ok);
    misaligned   = (((lsu_funct3 == F3_H) | (lsu_funct3 == F3_HU)) & lsu_addr[0]) |
                   ((lsu_funct3 == F3_W) & (lsu_addr[1:0] != 2'b00));
    // Addresses below BASE_ADDR wrap to large offsets and fail this compare too
    out_of_range = (offset >= SPAN);
    if (illegal)           fault_code = ERR_ILLEGAL;
    else if (misaligned)   fault_code = ERR_MISALIGN;
    else if (out_of_range) fault_code = ERR_RANGE;
    else                   fault_code = ERR_NONE;
    go = accept & (fault_code == ERR_NONE);
  end

  always_comb begin
    mem_cs   = go;
    mem_wr   = go & lsu_store;
    mem_addr = offset >> 2;
    mem_bwen = 4'b0000;
    mem_data = '0;
    if (go & lsu_store) begin
      mem_bwen = store_bwen(lsu_funct3, lsu_addr[1:0]);
      mem_data = store_lanes(lsu_funct3, lsu_wdata);
    end
  end

  // Stage boundary: accept -> LOAD_WAIT capture, error report, writeback register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      off_p1       <= 2'b00;
      funct3_p1    <= 3'b000;
      rd_p1        <= 5'd0;
      wb_valid     <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= '0;
      lsu_err      <= 1'b0;
      lsu_err_code <= ERR_NONE;
      lsu_err_addr <= '0;
    end else begin
      wb_valid <= 1'b0;
      lsu_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && fault_code != ERR_NONE) begin
            lsu_err      <= 1'b1;
            lsu_err_code <= fault_code;
            lsu_err_addr <= lsu_addr;
          end else if (go && lsu_load) begin
            off_p1    <= lsu_addr[1:0];
            funct3_p1 <= lsu_funct3;
            rd_p1     <= lsu_rd;
            state     <= LOAD_WAIT;
          end
        end
        LOAD_WAIT: begin
          wb_data  <= load_extend(mem_data_wb, off_p1, funct3_p1);
          wb_rd    <= rd_p1;
          wb_valid <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dtcm_ctrl.sv
// Scoreboard bench for lsu_dtcm_ctrl: directed requests push expected TCM strobes,
// writebacks and faults into queues; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_lsu_dtcm_ctrl;

  localparam logic [31:0] B = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic        lsu_load = 1'b0;
  logic        lsu_store = 1'b0;
  logic [2:0]  lsu_funct3 = 3'd0;
  logic [31:0] lsu_addr = 32'd0;
  logic [31:0] lsu_wdata = 32'd0;
  logic [4:0]  lsu_rd = 5'd0;
  logic        mem_cs;
  logic        mem_wr;
  logic [3:0]  mem_bwen;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [31:0] mem_data_wb;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lsu_err;
  logic [1:0]  lsu_err_code;
  logic [31:0] lsu_err_addr;

  lsu_dtcm_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_load(lsu_load), .lsu_store(lsu_store),
    .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_rd(lsu_rd),
    .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_bwen(mem_bwen), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_data_wb(mem_data_wb),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .lsu_err(lsu_err), .lsu_err_code(lsu_err_code), .lsu_err_addr(lsu_err_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural TCM: byte-enabled writes, one-cycle registered reads
  logic [31:0] tcm [256];
  logic [31:0] tcm_rdata = 32'd0;
  assign mem_data_wb = tcm_rdata;
  initial begin
    for (int i = 0; i < 256; i++) tcm[i] = 32'd0;
    tcm[0] = 32'h8001_7F80;
  end
  always @(posedge clk) begin
    if (mem_cs && mem_wr) begin
      for (int k = 0; k < 4; k++)
        if (mem_bwen[k]) tcm[mem_addr[7:0]][8*k +: 8] <= mem_data[8*k +: 8];
    end else if (mem_cs) begin
      tcm_rdata <= tcm[mem_addr[7:0]];
    end
  end

  typedef struct { logic cs; logic wr; logic [3:0] bw; logic [31:0] a; logic [31:0] d; } mem_t;
  typedef struct { int due; logic [4:0] rd; logic [31:0] d; } wb_t;
  typedef struct { int due; logic [1:0] code; logic [31:0] a; } err_t;
  mem_t mem_q[$];
  wb_t  wb_q[$];
  err_t err_q[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Monitor
  always @(negedge clk) begin
    mem_t me;
    wb_t  we;
    err_t ee;
    if (lsu_valid && lsu_ready) begin
      if (mem_q.size() == 0) flag("mem_unexpected_accept");
      else begin
        me = mem_q.pop_front();
        chk("mem_cs", mem_cs, me.cs);
        if (me.cs) begin
          chk("mem_wr", mem_wr, me.wr);
          chk("mem_bwen", mem_bwen, me.bw);
          chk("mem_addr", mem_addr, me.a);
          if (me.wr) chk("mem_data", mem_data, me.d);
        end
      end
    end else if (lsu_valid) begin
      chk("mem_cs_stall", mem_cs, 1'b0);
    end

    if (wb_valid) begin
      chk("wb_err_exclusive", lsu_err, 1'b0);
      if (wb_q.size() == 0) flag("wb_unexpected");
      else begin
        we = wb_q.pop_front();
        chk("wb_cycle", cyc, we.due);
        chk("wb_rd", wb_rd, we.rd);
        chk("wb_data", wb_data, we.d);
      end
    end else if (wb_q.size() != 0 && wb_q[0].due < cyc) begin
      flag("wb_missing");
      void'(wb_q.pop_front());
    end

    if (lsu_err) begin
      if (err_q.size() == 0) flag("err_unexpected");
      else begin
        ee = err_q.pop_front();
        chk("err_cycle", cyc, ee.due);
        chk("err_code", lsu_err_code, ee.code);
        chk("err_addr", lsu_err_addr, ee.a);
      end
    end else if (err_q.size() != 0 && err_q[0].due < cyc) begin
      flag("err_missing");
      void'(err_q.pop_front());
    end

    if (wb_q.size() != 0 && wb_q[0].due == cyc + 1) chk("ready_in_load_wait", lsu_ready, 1'b0);
  end

  // kind: 0 no response, 1 writeback of eval, 2 fault with ecode at address eval
  task automatic req(input logic ld, input logic st, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                     input logic ecs, input logic ewr, input logic [3:0] ebw,
                     input logic [31:0] eaddr, input logic [31:0] edata,
                     input int kind, input logic [31:0] eval, input logic [1:0] ecode,
                     output int waits);
    mem_t m;
    wb_t  w;
    err_t e;
    @(posedge clk); #1;
    m = '{cs: ecs, wr: ewr, bw: ebw, a: eaddr, d: edata};
    mem_q.push_back(m);
    lsu_valid = 1'b1; lsu_load = ld; lsu_store = st; lsu_funct3 = f3;
    lsu_addr = addr; lsu_wdata = wdata; lsu_rd = rd;
    waits = 0;
    @(negedge clk);
    while (!lsu_ready && waits < 8) begin
      waits++;
      @(negedge clk);
    end
    if (!lsu_ready) begin
      flag("accept_timeout");
      void'(mem_q.pop_back());
    end else if (kind == 1) begin
      w = '{due: cyc + 2, rd: rd, d: eval};
      wb_q.push_back(w);
    end else if (kind == 2) begin
      e = '{due: cyc + 1, code: ecode, a: eval};
      err_q.push_back(e);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    lsu_valid = 1'b0; lsu_load = 1'b0; lsu_store = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_lsu_err", lsu_err, 1'b0);
    chk("rst_err_code", lsu_err_code, 2'd0);
    chk("rst_err_addr", lsu_err_addr, 32'd0);
    chk("rst_ready", lsu_ready, 1'b1);
    rst_n = 1'b1;

    // Word store
    req(0, 1, 3'd2, B + 32'h10, 32'hDEAD_BEEF, 5'd0, 1, 1, 4'hF, 32'd4, 32'hDEAD_BEEF, 0, 32'd0, 2'd0, w);
    idle();
    // Byte store to lane 3, then byte loads back
    req(0, 1, 3'd0, B + 32'h13, 32'h0000_005A, 5'd0, 1, 1, 4'h8, 32'd4, 32'h5A5A_5A5A, 0, 32'd0, 2'd0, w);
    req(1, 0, 3'd4, B + 32'h13, 32'd0, 5'd3, 1, 0, 4'h0, 32'd4, 32'd0, 1, 32'h0000_005A, 2'd0, w);
    req(1, 0, 3'd0, B + 32'h13, 32'd0, 5'd4, 1, 0, 4'h0, 32'd4, 32'd0, 1, 32'h0000_005A, 2'd0, w);
    // Extension cases on preloaded word 0 = 8001_7F80
    req(1, 0, 3'd1, B + 32'h2, 32'd0, 5'd5,  1, 0, 4'h0, 32'd0, 32'd0, 1, 32'hFFFF_8001, 2'd0, w);
    req(1, 0, 3'd5, B + 32'h2, 32'd0, 5'd6,  1, 0, 4'h0, 32'd0, 32'd0, 1, 32'h0000_8001, 2'd0, w);
    req(1, 0, 3'd0, B,         32'd0, 5'd7,  1, 0, 4'h0, 32'd0, 32'd0, 1, 32'hFFFF_FF80, 2'd0, w);
    req(1, 0, 3'd2, B,         32'd0, 5'd8,  1, 0, 4'h0, 32'd0, 32'd0, 1, 32'h8001_7F80, 2'd0, w);
    req(1, 0, 3'd0, B + 32'h1, 32'd0, 5'd9,  1, 0, 4'h0, 32'd0, 32'd0, 1, 32'h0000_007F, 2'd0, w);
    req(1, 0, 3'd1, B,         32'd0, 5'd10, 1, 0, 4'h0, 32'd0, 32'd0, 1, 32'h0000_7F80, 2'd0, w);
    req(1, 0, 3'd4, B,         32'd0, 5'd11, 1, 0, 4'h0, 32'd0, 32'd0, 1, 32'h0000_0080, 2'd0, w);
    // Last TCM word, upper halfword
    req(0, 1, 3'd1, B + 32'h3FE, 32'h0000_C3A5, 5'd0, 1, 1, 4'hC, 32'd255, 32'hC3A5_C3A5, 0, 32'd0, 2'd0, w);
    req(1, 0, 3'd5, B + 32'h3FE, 32'd0, 5'd12, 1, 0, 4'h0, 32'd255, 32'd0, 1, 32'h0000_C3A5, 2'd0, w);
    req(1, 0, 3'd1, B + 32'h3FE, 32'd0, 5'd13, 1, 0, 4'h0, 32'd255, 32'd0, 1, 32'hFFFF_C3A5, 2'd0, w);

    // Faults, issued back to back
    req(1, 0, 3'd2, B + 32'h2,   32'd0, 5'd1, 0, 0, 4'h0, 32'd0, 32'd0, 2, B + 32'h2,   2'd1, w);
    req(0, 1, 3'd1, B + 32'h400, 32'd0, 5'd1, 0, 0, 4'h0, 32'd0, 32'd0, 2, B + 32'h400, 2'd2, w);
    req(1, 0, 3'd2, B - 32'h4,   32'd0, 5'd1, 0, 0, 4'h0, 32'd0, 32'd0, 2, B - 32'h4,   2'd2, w);
    req(1, 0, 3'd3, B,           32'd0, 5'd1, 0, 0, 4'h0, 32'd0, 32'd0, 2, B,           2'd3, w);
    req(1, 0, 3'd7, B + 32'h1,   32'd0, 5'd1, 0, 0, 4'h0, 32'd0, 32'd0, 2, B + 32'h1,   2'd3, w);
    req(0, 1, 3'd4, B,           32'd0, 5'd1, 0, 0, 4'h0, 32'd0, 32'd0, 2, B,           2'd3, w);
    req(1, 1, 3'd2, B,           32'd0, 5'd1, 0, 0, 4'h0, 32'd0, 32'd0, 2, B,           2'd3, w);
    req(0, 0, 3'd2, B,           32'd0, 5'd1, 0, 0, 4'h0, 32'd0, 32'd0, 2, B,           2'd3, w);
    req(1, 0, 3'd1, B + 32'h1,   32'd0, 5'd1, 0, 0, 4'h0, 32'd0, 32'd0, 2, B + 32'h1,   2'd1, w);
    req(0, 1, 3'd2, B + 32'h402, 32'd0, 5'd1, 0, 0, 4'h0, 32'd0, 32'd0, 2, B + 32'h402, 2'd1, w);

    // Load followed immediately by a store: store stalls one cycle, lands with wb_valid
    req(1, 0, 3'd2, B + 32'h10, 32'd0, 5'd13, 1, 0, 4'h0, 32'd4, 32'd0, 1, 32'h5AAD_BEEF, 2'd0, w);
    req(0, 1, 3'd1, B + 32'h22, 32'h1234_ABCD, 5'd0, 1, 1, 4'hC, 32'd8, 32'hABCD_ABCD, 0, 32'd0, 2'd0, w);
    chk("store_stall_cycles", w, 1);
    req(1, 0, 3'd5, B + 32'h22, 32'd0, 5'd14, 1, 0, 4'h0, 32'd8, 32'd0, 1, 32'h0000_ABCD, 2'd0, w);
    req(0, 1, 3'd0, B + 32'h21, 32'h0000_00FF, 5'd0, 1, 1, 4'h2, 32'd8, 32'hFFFF_FFFF, 0, 32'd0, 2'd0, w);
    req(1, 0, 3'd0, B + 32'h21, 32'd0, 5'd15, 1, 0, 4'h0, 32'd8, 32'd0, 1, 32'hFFFF_FFFF, 2'd0, w);
    idle();
    repeat (3) @(posedge clk);

    // Reset during LOAD_WAIT discards the load
    req(1, 0, 3'd2, B, 32'd0, 5'd20, 1, 0, 4'h0, 32'd0, 32'd0, 0, 32'd0, 2'd0, w);
    idle();
    @(negedge clk); #2;
    chk("pre_rst_ready_low", lsu_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_wb_valid", wb_valid, 1'b0);
    chk("async_rst_wb_data", wb_data, 32'd0);
    chk("async_rst_wb_rd", wb_rd, 5'd0);
    chk("async_rst_err_code", lsu_err_code, 2'd0);
    chk("async_rst_err_addr", lsu_err_addr, 32'd0);
    chk("async_rst_ready", lsu_ready, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    req(1, 0, 3'd4, B + 32'h3, 32'd0, 5'd21, 1, 0, 4'h0, 32'd0, 32'd0, 1, 32'h0000_0080, 2'd0, w);
    idle();
    repeat (5) @(posedge clk);

    chk("mem_q_drained", mem_q.size(), 0);
    chk("wb_q_drained", wb_q.size(), 0);
    chk("err_q_drained", err_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
